// File: rtl/pipe_reg_hs.sv
// pipe_reg_hs: two-entry pipeline register with a valid/ready handshake.
// The main entry drives the outputs. The skid entry catches one beat
// while downstream stalls. Because of this, in_ready is a pure register
// output and has no combinational path from out_ready.
module pipe_reg_hs #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  logic xfer_in;
  logic xfer_out;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  // Bubbles must look like no-ops downstream, so the control fields are
  // forced to zero whenever the head entry is not live.
  assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  assign xfer_in  = in_valid & ~skid_valid_q;
  assign xfer_out = main_valid_q & out_ready;

  // Next-state logic: skid drain, load of main or skid, and flush override.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (skid_valid_q) begin
      // A full stage cannot accept input. It can only shift skid into main.
      if (xfer_out) begin
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (xfer_in) begin
      if (!main_valid_q || xfer_out) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end
    end else if (xfer_out) begin
      main_valid_d = 1'b0;
    end

    // Flush squashes only the valid bits. Any stale payload stays in the
    // data registers but is masked by the cleared valids.
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  // State registers. Reset is asynchronous so that held entries vanish at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Testbench for pipe_reg_hs. The reference model is a capacity-2 FIFO
// queue that runs next to the DUT and is checked on every falling edge.
// Directed scenarios add literal expectations, and a long random phase follows.
module tb_pipe_reg_hs;
  localparam int DW = 101;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  // Model queue entries are stored as {ctrl, data}.
  logic [CW+DW-1:0] q[$];

  pipe_reg_hs #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // The model checks DUT outputs on the falling edge. It then applies the
  // transfer that the next rising edge will perform.
  always @(negedge clk) begin
    logic xin, xout;
    check("model_occupancy", 128'(occupancy), 128'(q.size()));
    check("model_in_ready",  128'(in_ready),  128'(q.size() < 2));
    check("model_out_valid", 128'(out_valid), 128'(q.size() > 0));
    if (q.size() > 0) begin
      check("model_out_data", 128'(out_data), 128'(q[0][DW-1:0]));
      check("model_out_ctrl", 128'(out_ctrl), 128'(q[0][CW+DW-1:DW]));
    end else begin
      check("model_bubble_ctrl", 128'(out_ctrl), 128'(0));
    end
    if (!reset) begin
      if (flush) begin
        q.delete();
      end else begin
        xout = (q.size() > 0) && out_ready;
        xin  = in_valid && (q.size() < 2);
        if (xout) void'(q.pop_front());
        if (xin)  q.push_back({in_ctrl, in_data});
      end
    end
  end

  // Applies one cycle of inputs and returns at posedge+1, when the
  // outputs from that edge are stable.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] r;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data",  128'(out_data),  128'(0));
    check("rst_out_ctrl",  128'(out_ctrl),  128'(0));
    check("rst_occupancy", 128'(occupancy), 128'(0));
    check("rst_in_ready",  128'(in_ready),  128'(1));
    reset = 1'b0;

    // A single beat takes one cycle of latency.
    step(1'b1, DW'('h5), 3'b101, 1'b1, 1'b0);
    check("lat_out_valid", 128'(out_valid), 128'(1));
    check("lat_out_data",  128'(out_data),  128'(5));
    check("lat_out_ctrl",  128'(out_ctrl),  128'(5));
    check("lat_occupancy", 128'(occupancy), 128'(1));
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // A streaming input gives full throughput.
    for (int i = 1; i <= 4; i++) begin
      check("stream_in_ready", 128'(in_ready), 128'(1));
      step(1'b1, DW'(i), 3'(i), 1'b1, 1'b0);
      check("stream_out_data", 128'(out_data), 128'(i));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // A stall fills the skid entry, then the stage drains in order.
    step(1'b1, DW'('hA), 3'd1, 1'b0, 1'b0);
    step(1'b1, DW'('hB), 3'd2, 1'b0, 1'b0);
    check("stall_occupancy", 128'(occupancy), 128'(2));
    check("stall_in_ready",  128'(in_ready),  128'(0));
    step(1'b1, DW'('hC), 3'd3, 1'b0, 1'b0);
    check("held_out_data", 128'(out_data), 128'('hA));
    step(1'b1, DW'('hC), 3'd3, 1'b1, 1'b0);
    check("drain_b", 128'(out_data), 128'('hB));
    step(1'b1, DW'('hC), 3'd3, 1'b1, 1'b0);
    check("drain_c", 128'(out_data), 128'('hC));
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // A flush of a full stage discards the beat offered in the same cycle.
    step(1'b1, DW'('hA), 3'd1, 1'b0, 1'b0);
    step(1'b1, DW'('hB), 3'd2, 1'b0, 1'b0);
    step(1'b1, DW'('hD), 3'd7, 1'b0, 1'b1);
    check("flush_occupancy", 128'(occupancy), 128'(0));
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_out_ctrl",  128'(out_ctrl),  128'(0));
    check("flush_in_ready",  128'(in_ready),  128'(1));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("flush_no_d", 128'(out_valid), 128'(0));

    // An asynchronous reset asserted between edges clears a full stage.
    step(1'b1, DW'('h11), 3'd1, 1'b0, 1'b0);
    step(1'b1, DW'('h22), 3'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_out_data",  128'(out_data),  128'(0));
    check("arst_in_ready",  128'(in_ready),  128'(1));
    check("arst_occupancy", 128'(occupancy), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // A random phase checks every cycle against the model queue.
    for (int n = 0; n < 10000; n++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 1)), r[DW-1:0], 3'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
    end
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
